// File: rtl/rf_wb_scheduler_if.sv
// Writeback-source bus for rf_wb_scheduler.
// The execute units (ALU=0, LSU=1, MDU=2) act as master and present
// valid/rd/data. The scheduler acts as slave and returns a one-hot grant.
interface rf_wb_scheduler_if #(
  parameter int NSRC = 3,
  parameter int DW   = 32
);
  logic [NSRC-1:0]    src_valid;
  logic [NSRC*5-1:0]  src_rd;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC-1:0]    src_ready;

  modport master (output src_valid, output src_rd, output src_data, input src_ready);
  modport slave  (input src_valid, input src_rd, input src_data, output src_ready);
endinterface

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: register-file writeback scheduler.
//  - Arbitrates three writeback sources onto the single regfile write port.
//    The write port is registered and has a 1-cycle latency.
//  - Tracks pending destination registers in a 32-entry busy scoreboard and
//    stalls issue on RAW/WAW hazards. r0 is never busy.
// Build option: define RF_WB_RR_EN for round-robin arbitration. By default the
// arbiter uses fixed priority LSU(1) > MDU(2) > ALU(0).
module rf_wb_scheduler (
  input  logic                   clk,
  input  logic                   reset,          // async, active-low
  input  logic                   issue_valid_i,
  input  logic [4:0]             issue_rj_i,
  input  logic [4:0]             issue_rk_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   issue_we_i,
  output logic                   issue_stall_o,
  input  logic                   flush_i,
  rf_wb_scheduler_if.slave       wb,
  output logic                   wb_en_o,
  output logic [4:0]             wb_rd_o,
  output logic [31:0]            wb_data_o,
  output logic                   idle_o
);

  localparam int NSRC = 3;

  logic [31:0] busy_q, busy_d;
  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        gnt_any_s;
  logic [1:0]  gnt_idx_s;
  logic        xfer_s;
  logic [4:0]  xfer_rd_s;
  logic [31:0] xfer_data_s;
  logic        accept_s;

`ifdef RF_WB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Source index (base + off) modulo NSRC, for base, off < NSRC.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Round-robin arbiter: pick the first valid source at or after rr_ptr.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (!gnt_any_s && wb.src_valid[wrap_idx(rr_ptr_q, 2'(i))]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = wrap_idx(rr_ptr_q, 2'(i));
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // After a transfer, the source following the winner gets first pick.
  always_comb begin
    if (xfer_s) begin
      rr_ptr_d = wrap_idx(gnt_idx_s, 2'd1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed-priority arbiter: LSU first, then MDU, then ALU.
  always_comb begin
    gnt_any_s = 1'b1;
    gnt_idx_s = 2'd0;
    if (wb.src_valid[1]) begin
      gnt_idx_s = 2'd1;
    end else if (wb.src_valid[2]) begin
      gnt_idx_s = 2'd2;
    end else if (wb.src_valid[0]) begin
      gnt_idx_s = 2'd0;
    end else begin
      gnt_any_s = 1'b0;
    end
  end
`endif

  // No grant while reset is asserted. A grant with valid is a transfer.
  assign xfer_s       = reset & gnt_any_s;
  assign wb.src_ready = xfer_s ? (3'b001 << gnt_idx_s) : 3'b000;

  // Route the winning source's address and data toward the write port.
  always_comb begin
    xfer_rd_s   = 5'd0;
    xfer_data_s = 32'd0;
    case (gnt_idx_s)
      2'd0: begin
        xfer_rd_s   = wb.src_rd[4:0];
        xfer_data_s = wb.src_data[31:0];
      end
      2'd1: begin
        xfer_rd_s   = wb.src_rd[9:5];
        xfer_data_s = wb.src_data[63:32];
      end
      2'd2: begin
        xfer_rd_s   = wb.src_rd[14:10];
        xfer_data_s = wb.src_data[95:64];
      end
      default: begin
        xfer_rd_s   = 5'd0;
        xfer_data_s = 32'd0;
      end
    endcase
  end

  // Hazard check uses only registered busy bits. A clear in this cycle does not bypass.
  assign issue_stall_o = issue_valid_i &
                         (busy_q[issue_rj_i] | busy_q[issue_rk_i] |
                          (issue_we_i & busy_q[issue_rd_i]));
  assign accept_s      = issue_valid_i & ~issue_stall_o & ~flush_i;

  // Scoreboard next state: clear on writeback, then set on issue (set wins).
  // Flush overrides both. r0 is forced clear.
  always_comb begin
    busy_d = busy_q;
    if (xfer_s) begin
      busy_d[xfer_rd_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (accept_s && issue_we_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (flush_i) begin
      busy_d = 32'd0;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard and registered write port. Address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= 32'd0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      wb_en_q <= xfer_s;
      if (xfer_s) begin
        wb_rd_q   <= xfer_rd_s;
        wb_data_q <= xfer_data_s;
      end else begin
        wb_rd_q   <= wb_rd_q;
        wb_data_q <= wb_data_q;
      end
    end
  end

  assign wb_en_o   = wb_en_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;
  assign idle_o    = (busy_q == 32'd0) & ~wb_en_q;

endmodule
